// File: rtl/mcss_sequencer_pkg.sv
// Shared types and width helpers for the MCSS front-end sequencer.
package mcss_pkg;

   typedef enum logic [1:0] {FILL, HOLD, ISSUE} state_e;

   function automatic int unsigned cnt_w(input int unsigned rows);
      return $clog2(rows);
   endfunction

   function automatic int unsigned cred_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/mcss_sequencer_if.sv
// Input word stream and result stream of the MCSS sequencer.
interface mcss_sequencer_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ID_W       = 8
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_last;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic [ID_W-1:0]       out_id;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_id
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_id
   );
endinterface

// File: rtl/mcss_result_fifo.sv
// Small synchronous result FIFO; push and pop may coincide at any occupancy.
module mcss_result_fifo #(
   parameter int unsigned DEPTH   = 4,
   parameter type         entry_t = logic [31:0]
) (
   input  logic   clk,
   input  logic   rst_l,
   input  logic   push,
   input  entry_t wdata,
   input  logic   pop,
   output entry_t rdata,
   output logic   full,
   output logic   empty
);
   localparam int unsigned PTR_W = $clog2(DEPTH);

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] wr_q, rd_q;
   logic [PTR_W:0]   cnt_q;
   logic             do_push, do_pop;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == (PTR_W+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = empty ? '0 : mem[rd_q];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_q] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + PTR_W'(1);
         if (do_pop)  rd_q <= rd_q + PTR_W'(1);
         cnt_q <= cnt_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
      end
   end
endmodule

// File: rtl/mcss_sequencer.sv
// Packs stream frames into tree vectors, tracks tree latency and queues results under credits.
module mcss_sequencer
   import mcss_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ROWS       = 256,
   parameter int unsigned LAT        = $clog2(ROWS),
   parameter int unsigned RES_DEPTH  = 4,
   parameter int unsigned ID_W       = 8
) (
   input  logic                       clk,
   input  logic                       rst_l,
   mcss_sequencer_if.slave            bus,
   output logic [ROWS*DATA_WIDTH-1:0] vec_out,
   input  logic [DATA_WIDTH-1:0]      mcss_val,
   output logic                       busy
);
   localparam int unsigned CNT_W  = cnt_w(ROWS);
   localparam int unsigned CRED_W = cred_w(RES_DEPTH);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [ID_W-1:0]       id;
   } res_t;

   state_e                     state_q;
   logic [ROWS*DATA_WIDTH-1:0] buf_q;
   logic [CNT_W-1:0]           cnt_q;
   logic [ID_W-1:0]            id_q;
   logic                       in_ready_q;
   logic [CRED_W-1:0]          cred_q;
   logic [LAT-1:0]             pipe_vld_q;
   logic [ID_W-1:0]            pipe_tag_q [LAT];

   logic in_hs, frame_done, issue, avail;
   logic res_push, res_pop, fifo_full, fifo_empty;
   res_t res_head;

   assign in_hs      = bus.in_valid && in_ready_q;
   assign frame_done = bus.in_last || (cnt_q == CNT_W'(ROWS - 1));
   assign issue      = (state_q == ISSUE);
   assign res_pop    = bus.out_ready && !fifo_empty;
   // A pop in the same cycle frees a slot, so it already counts as a credit.
   assign avail      = (cred_q != '0) || res_pop;

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q    <= FILL;
         buf_q      <= '0;
         cnt_q      <= '0;
         id_q       <= '0;
         in_ready_q <= 1'b1;
      end else begin
         unique case (state_q)
            FILL: begin
               if (in_hs) begin
                  buf_q[DATA_WIDTH*int'(cnt_q) +: DATA_WIDTH] <= bus.in_data;
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (frame_done) begin
                     state_q    <= avail ? ISSUE : HOLD;
                     in_ready_q <= 1'b0;
                  end
               end
            end
            HOLD: begin
               if (avail) state_q <= ISSUE;
            end
            ISSUE: begin
               // The tree samples the old buffer on this same edge.
               buf_q      <= '0;
               cnt_q      <= '0;
               id_q       <= id_q + ID_W'(1);
               state_q    <= FILL;
               in_ready_q <= 1'b1;
            end
            default: state_q <= FILL;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         cred_q     <= CRED_W'(RES_DEPTH);
         pipe_vld_q <= '0;
         for (int i = 0; i < LAT; i++) pipe_tag_q[i] <= '0;
      end else begin
         cred_q        <= cred_q - CRED_W'(issue) + CRED_W'(res_pop);
         pipe_vld_q[0] <= issue;
         pipe_tag_q[0] <= id_q;
         for (int i = 1; i < LAT; i++) begin
            pipe_vld_q[i] <= pipe_vld_q[i-1];
            pipe_tag_q[i] <= pipe_tag_q[i-1];
         end
      end
   end

   assign res_push = pipe_vld_q[LAT-1];

   mcss_result_fifo #(
      .DEPTH   (RES_DEPTH),
      .entry_t (res_t)
   ) u_fifo (
      .clk   (clk),
      .rst_l (rst_l),
      .push  (res_push),
      .wdata ('{data: mcss_val, id: pipe_tag_q[LAT-1]}),
      .pop   (res_pop),
      .rdata (res_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign vec_out      = buf_q;
   assign bus.in_ready = in_ready_q;
   assign bus.out_valid = !fifo_empty;
   assign bus.out_data = res_head.data;
   assign bus.out_id   = res_head.id;
   assign busy = (cnt_q != '0) | (state_q != FILL) | (|pipe_vld_q) | !fifo_empty;

   assert property (@(posedge clk) disable iff (!rst_l) !(res_push && fifo_full && !res_pop));
   assert property (@(posedge clk) disable iff (!rst_l) cred_q <= CRED_W'(RES_DEPTH));
endmodule
